uart_tx: RTL and testbench

Serial UART transmitter, the transmit-side companion to the design's UART receiver: it accepts bytes from on-chip logic through a 4-entry FIFO and shifts them out on the TX line as 8N1 frames at a fixed baud rate. An optional parity bit can be compiled in. It sits between the control logic and the board's UART TX pin, at the same baud rate and system clock as the receiver.

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with 4-entry byte FIFO; optional parity bit via UART_TX_PARITY_EN.
// Line goes low one cycle after a write into an idle block; tx_ready drops while the FIFO is full.
module uart_tx #(
    parameter int BAUD_END   = 5207,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       s_clk,
    input  logic       s_rst,
    input  logic [7:0] data_tx,
    input  logic       tx_flag,
    output logic       tx_ready,
    output logic       data_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [12:0] BAUD_LAST = 13'(BAUD_END);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [12:0] baud_cnt;
    logic        bit_end;
    logic        push, pop, shift_en, bit_clr, line_nxt, done_nxt;

`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`else
    logic        unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    assign tx_ready = (count != 3'd4);
    assign tx_busy  = (state != IDLE);
    assign bit_end  = (baud_cnt == BAUD_LAST);
    // A full FIFO drops the write even if a pop frees a slot in the same cycle.
    assign push     = tx_flag && (count != 3'd4);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        shift_en  = 1'b0;
        bit_clr   = 1'b0;
        line_nxt  = data_out;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                line_nxt = 1'b1;
                if (count != 3'd0) begin
                    pop       = 1'b1;
                    line_nxt  = 1'b0;
                    state_nxt = START;
                end
            end
            START: if (bit_end) begin
                line_nxt  = shift[0];
                bit_clr   = 1'b1;
                state_nxt = DATA;
            end
            DATA: if (bit_end) begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    line_nxt  = parity_bit;
                    state_nxt = PARITY;
`else
                    line_nxt  = 1'b1;
                    state_nxt = STOP;
`endif
                end else begin
                    line_nxt = shift[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                line_nxt  = 1'b1;
                state_nxt = STOP;
            end
`endif
            STOP: if (bit_end) begin
                done_nxt = 1'b1;
                // Chain straight into the next start bit so queued frames have no idle gap.
                if (count != 3'd0) begin
                    pop       = 1'b1;
                    line_nxt  = 1'b0;
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                line_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge s_clk) begin
        if (push) mem[wr_ptr] <= data_tx;
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state    <= IDLE;
            data_out <= 1'b1;
            tx_done  <= 1'b0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            shift    <= 8'd0;
            bit_cnt  <= 3'd0;
            baud_cnt <= 13'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            data_out <= line_nxt;
            tx_done  <= done_nxt;

            if (state == IDLE || bit_end) baud_cnt <= 13'd0;
            else                          baud_cnt <= baud_cnt + 13'd1;

            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (pop) begin
                shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^mem[rd_ptr]) ^ PARITY_ODD;
`endif
            end else if (shift_en) begin
                shift <= {1'b0, shift[7:1]};
            end

            if (bit_clr)       bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboard of accepted bytes checked against a line decoder.
module tb_uart_tx;
    localparam int  BAUD_END = 15;
    localparam int  B        = BAUD_END + 1;
    localparam bit  PODD     = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int  NB = 11;
`else
    localparam int  NB = 10;
`endif

    logic       s_clk = 1'b0;
    logic       s_rst = 1'b1;
    logic [7:0] data_tx = 8'd0;
    logic       tx_flag = 1'b0;
    logic       tx_ready, data_out, tx_busy, tx_done;

    int         tests = 0, errs = 0;
    int         done_cnt = 0, frames_rx = 0, exp_frames = 0;
    bit         mon_abort = 1'b0;
    logic [7:0] sb[$];

    uart_tx #(.BAUD_END(BAUD_END), .PARITY_ODD(PODD)) dut (
        .s_clk(s_clk), .s_rst(s_rst), .data_tx(data_tx), .tx_flag(tx_flag),
        .tx_ready(tx_ready), .data_out(data_out), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
        logic [NB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = (^b) ^ PODD;
`endif
        return f;
    endfunction

    task automatic wait_idle(input string tag, input int limit, output int n);
        n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin
            @(negedge s_clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < limit), 32'd1);
    endtask

    always @(negedge s_clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    // Line decoder: checks every cycle of each frame against the expected bit pattern.
    initial begin
        logic [NB-1:0] exp_f;
        logic [7:0]    b, got_b;
        int            bad;
        bit            ab, skip_adv;
        skip_adv = 1'b0;
        forever begin
            if (!skip_adv) @(negedge s_clk);
            skip_adv = 1'b0;
            if (mon_abort || data_out !== 1'b0) continue;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
                b = 8'd0;
            end else begin
                b = sb.pop_front();
            end
            exp_f = frame_of(b);
            bad = 0; got_b = 8'd0; ab = 1'b0;
            for (int c = 0; c < NB * B; c++) begin
                if (c != 0) @(negedge s_clk);
                if (mon_abort) begin ab = 1'b1; break; end
                if (data_out !== exp_f[c / B]) bad++;
                if (c != 0 && tx_done !== 1'b0) bad++;
                if (c % B == B / 2 && c / B >= 1 && c / B <= 8) got_b[c / B - 1] = data_out;
            end
            if (!ab) begin
                chk("frame_bits", 32'(bad), 32'd0);
                chk("frame_byte", 32'(got_b), 32'(b));
                @(negedge s_clk);
                chk("frame_done", 32'(tx_done), 32'd1);
                frames_rx++;
                skip_adv = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n, n2, cnt, acc, nacc, lows, d0;
        logic [7:0] burst [6];

        repeat (3) @(negedge s_clk);
        chk("rst_line",  32'(data_out), 32'd1);
        chk("rst_busy",  32'(tx_busy),  32'd0);
        chk("rst_done",  32'(tx_done),  32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        s_rst = 1'b0;

        lows = 0;
        repeat (1000) begin
            @(negedge s_clk);
            if (data_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) lows++;
        end
        chk("idle_line", 32'(lows), 32'd0);
        chk("idle_done", 32'(done_cnt), 32'd0);

        // Single byte: start bit one cycle after acceptance, frame exactly NB bit times.
        @(negedge s_clk); data_tx = 8'h55; tx_flag = 1'b1; sb.push_back(8'h55); exp_frames++;
        @(negedge s_clk); tx_flag = 1'b0;
        chk("lat_hold",  32'(data_out), 32'd1);
        chk("lat_busy0", 32'(tx_busy),  32'd0);
        @(negedge s_clk);
        chk("lat_start", 32'(data_out), 32'd0);
        chk("lat_busy1", 32'(tx_busy),  32'd1);
        wait_idle("f55", 2 * NB * B, n);
        chk("f55_len", 32'(n), 32'(NB * B));

        // Burst of six writes; acceptance predicted from a FIFO occupancy model.
        burst = '{8'hA3, 8'h0F, 8'hFF, 8'h00, 8'h12, 8'h5A};
        cnt = 0; nacc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge s_clk);
            chk("rdy_burst", 32'(tx_ready), 32'(cnt < 4));
            acc = (cnt < 4) ? 1 : 0;
            data_tx = burst[i]; tx_flag = 1'b1;
            if (acc == 1) begin sb.push_back(burst[i]); nacc++; exp_frames++; end
            cnt = cnt + acc - ((i == 1) ? 1 : 0);
        end
        @(negedge s_clk); tx_flag = 1'b0;
        chk("rdy_full", 32'(tx_ready), 32'(cnt < 4));
        n = 0;
        while (tx_ready !== 1'b1 && n < 2 * NB * B) begin @(negedge s_clk); n++; end
        chk("rdy_rise", 32'(n), 32'(NB * B - 4));
        wait_idle("burst", 8 * NB * B, n2);
        chk("burst_len", 32'(n + n2), 32'(nacc * NB * B - 4));

        // Reset in the middle of a frame with bytes queued.
        @(negedge s_clk); data_tx = 8'hC3; tx_flag = 1'b1; sb.push_back(8'hC3);
        @(negedge s_clk); data_tx = 8'h11; sb.push_back(8'h11);
        @(negedge s_clk); data_tx = 8'h22; sb.push_back(8'h22);
        @(negedge s_clk); tx_flag = 1'b0;
        repeat (5 * B) @(negedge s_clk);
        mon_abort = 1'b1; s_rst = 1'b1;
        @(negedge s_clk); s_rst = 1'b0;
        chk("mid_line",  32'(data_out), 32'd1);
        chk("mid_busy",  32'(tx_busy),  32'd0);
        chk("mid_ready", 32'(tx_ready), 32'd1);
        chk("mid_done",  32'(tx_done),  32'd0);
        d0 = done_cnt;
        sb.delete();
        repeat (3) @(negedge s_clk);
        mon_abort = 1'b0;
        lows = 0;
        repeat (3 * NB * B) begin
            @(negedge s_clk);
            if (data_out !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk("flush_line", 32'(lows), 32'd0);
        chk("flush_done", 32'(done_cnt), 32'(d0));

        // Bytes with odd and even bit counts (parity 1 and 0 when parity is built in).
        @(negedge s_clk); data_tx = 8'h07; tx_flag = 1'b1; sb.push_back(8'h07); exp_frames++;
        @(negedge s_clk); data_tx = 8'h03; sb.push_back(8'h03); exp_frames++;
        @(negedge s_clk); tx_flag = 1'b0;
        wait_idle("par", 4 * NB * B, n);
        chk("par_len", 32'(n), 32'(2 * NB * B));

        // Write landing on the edge that ends the previous stop bit.
        @(negedge s_clk); data_tx = 8'h3C; tx_flag = 1'b1; sb.push_back(8'h3C); exp_frames++;
        @(negedge s_clk); tx_flag = 1'b0;
        repeat (NB * B) @(negedge s_clk);
        data_tx = 8'h81; tx_flag = 1'b1; sb.push_back(8'h81); exp_frames++;
        @(negedge s_clk); tx_flag = 1'b0;
        chk("gap_busy", 32'(tx_busy),  32'd0);
        chk("gap_line", 32'(data_out), 32'd1);
        @(negedge s_clk);
        chk("gap_start", 32'(data_out), 32'd0);
        chk("gap_busy1", 32'(tx_busy),  32'd1);
        wait_idle("f81", 2 * NB * B, n);
        chk("f81_len", 32'(n), 32'(NB * B));

        repeat (5) @(negedge s_clk);
        chk("sb_empty",   32'(sb.size()), 32'd0);
        chk("frames",     32'(frames_rx), 32'(exp_frames));
        chk("done_total", 32'(done_cnt),  32'(exp_frames));
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
